ppi_bus_master: RTL and testbench

//  Synchronous host-side master driving the 8255 PPI bus pins (A, CS, READ, WRITE, DATA).

---
 rtl/ppi_bus_pkg.sv | 31 +++
 rtl/ppi_phase_counter.sv | 42 ++++
 rtl/ppi_bus_master.sv | 217 +++++++++++++++++++++
 tb/tb_ppi_bus_master.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ppi_bus_pkg.sv
// ----------------------------------------------------------------------------
// ppi_bus_pkg
// Shared definitions for the 8255 PPI bus master:
//   - FSM state encodings (IDLE, INIT, SETUP, STROBE, HOLD)
//   - PPI register address constants
//   - default control word written by the optional init sequence
//   - helper that tells whether a state drives an active bus cycle
// ----------------------------------------------------------------------------
package ppi_bus_pkg;

  typedef logic [2:0] ppi_state_t;

  localparam ppi_state_t ST_IDLE   = 3'd0;
  localparam ppi_state_t ST_INIT   = 3'd1;
  localparam ppi_state_t ST_SETUP  = 3'd2;
  localparam ppi_state_t ST_STROBE = 3'd3;
  localparam ppi_state_t ST_HOLD   = 3'd4;

  localparam logic [1:0] PPI_PA   = 2'b00;
  localparam logic [1:0] PPI_PB   = 2'b01;
  localparam logic [1:0] PPI_PC   = 2'b10;
  localparam logic [1:0] PPI_CTRL = 2'b11;

  localparam logic [7:0] PPI_CTRL_WORD_DEFAULT = 8'h9B;

  // CS is asserted for the whole SETUP/STROBE/HOLD sequence.
  function automatic logic is_bus_active(input ppi_state_t st);
    return (st == ST_SETUP) || (st == ST_STROBE) || (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/ppi_phase_counter.sv
// ----------------------------------------------------------------------------
// ppi_phase_counter
// Load/decrement counter timing one bus phase. Loaded with the phase length on
// phase entry; last_o is high during the final cycle of the phase (count == 1).
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - synchronous active-low reset
//   load_i     - load load_val_i this edge (otherwise count down to 0)
//   load_val_i - phase length in cycles
//   last_o     - current cycle is the last one of the phase
// ----------------------------------------------------------------------------
module ppi_phase_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] cnt_q;

  // Phase counter: reload on phase entry, saturate at zero while idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= CNT_ZERO;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != CNT_ZERO) begin
      cnt_q <= cnt_q - CNT_ONE;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign last_o = (cnt_q == CNT_ONE);

endmodule

// File: rtl/ppi_bus_master.sv
// ----------------------------------------------------------------------------
// ppi_bus_master
// Host-side master for the 8255 PPI bus. Accepts one valid/ready request at a
// time and runs a SETUP -> STROBE -> HOLD cycle with programmable widths. Read
// data is captured at the end of the strobe and returned with a one-cycle
// RSP_VALID pulse on the first IDLE cycle. Every bus pin is driven from a flop.
// Optional feature macro: PPI_INIT_SEQ_EN -- after reset the master writes
// CTRL_WORD to the control register before accepting requests.
// Ports:
//   CLK, RESET_N          - clock, synchronous active-low reset
//   REQ_VALID/REQ_READY   - request handshake (READY only in IDLE)
//   REQ_WRITE/ADDR/WDATA  - request direction, PPI register, write data
//   RSP_VALID/RSP_DATA    - read completion pulse and held read data
//   BUSY                  - master not in IDLE
//   PPI_RESET             - active-high reset towards the PPI
//   A, CS, READ, WRITE    - PPI address and active-low controls
//   DATA                  - PPI data bus, driven only during write cycles
// ----------------------------------------------------------------------------
module ppi_bus_master
  import ppi_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned CNT_W      = 4,
  parameter logic [7:0]  CTRL_WORD  = PPI_CTRL_WORD_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WRITE,
  input  logic [1:0] REQ_ADDR,
  input  logic [7:0] REQ_WDATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       BUSY,
  output logic       PPI_RESET,
  output logic [1:0] A,
  output logic       CS,
  output logic       READ,
  output logic       WRITE,
  inout  wire  [7:0] DATA
);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC);

`ifdef PPI_INIT_SEQ_EN
  localparam ppi_state_t RESET_STATE = ST_INIT;
`else
  localparam ppi_state_t RESET_STATE = ST_IDLE;
`endif

  ppi_state_t       state_q, state_d;
  logic             lat_write_q, lat_write_d;
  logic [1:0]       lat_addr_q, lat_addr_d;
  logic [7:0]       lat_wdata_q, lat_wdata_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             cs_q, cs_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [1:0]       a_q, a_d;
  logic             drv_q, drv_d;
  logic             ppi_reset_q;
  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_val_s;
  logic             cnt_last_s;
  logic             active_s;

  ppi_phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk_i      (CLK),
    .rst_ni     (RESET_N),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_val_s),
    .last_o     (cnt_last_s)
  );

  // Next-state logic: phase sequencing, request latch, read capture.
  always_comb begin
    state_d     = state_q;
    lat_write_d = lat_write_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_val_s   = SETUP_LD;
    case (state_q)
      ST_IDLE: begin
        // ready_q is the registered REQ_READY, so requests seen while it is low are dropped.
        if (REQ_VALID && ready_q) begin
          lat_write_d = REQ_WRITE;
          lat_addr_d  = REQ_ADDR;
          lat_wdata_d = REQ_WDATA;
          state_d     = ST_SETUP;
          cnt_load_s  = 1'b1;
          cnt_val_s   = SETUP_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef PPI_INIT_SEQ_EN
      ST_INIT: begin
        lat_write_d = 1'b1;
        lat_addr_d  = PPI_CTRL;
        lat_wdata_d = CTRL_WORD;
        state_d     = ST_SETUP;
        cnt_load_s  = 1'b1;
        cnt_val_s   = SETUP_LD;
      end
`endif
      ST_SETUP: begin
        if (cnt_last_s) begin
          state_d    = ST_STROBE;
          cnt_load_s = 1'b1;
          cnt_val_s  = STROBE_LD;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_STROBE: begin
        if (cnt_last_s) begin
          state_d    = ST_HOLD;
          cnt_load_s = 1'b1;
          cnt_val_s  = HOLD_LD;
          // The PPI still drives DATA here: READ only rises after this edge.
          if (!lat_write_q) begin
            rsp_data_d = DATA;
          end else begin
            rsp_data_d = rsp_data_q;
          end
        end else begin
          state_d = ST_STROBE;
        end
      end
      ST_HOLD: begin
        if (cnt_last_s) begin
          state_d     = ST_IDLE;
          rsp_valid_d = ~lat_write_q;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus pin next values, derived from the next state so every pin is a flop output.
  always_comb begin
    active_s = is_bus_active(state_d);
    cs_d     = ~active_s;
    if (active_s) begin
      a_d = lat_addr_d;
    end else begin
      a_d = a_q;
    end
    drv_d   = active_s & lat_write_d;
    rd_d    = ~((state_d == ST_STROBE) & ~lat_write_d);
    wr_d    = ~((state_d == ST_STROBE) &  lat_write_d);
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any cycle in progress.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= RESET_STATE;
      lat_write_q <= 1'b0;
      lat_addr_q  <= PPI_PA;
      lat_wdata_q <= CTRL_WORD;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      cs_q        <= 1'b1;
      rd_q        <= 1'b1;
      wr_q        <= 1'b1;
      a_q         <= PPI_PA;
      drv_q       <= 1'b0;
      ppi_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      lat_write_q <= lat_write_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      a_q         <= a_d;
      drv_q       <= drv_d;
      ppi_reset_q <= 1'b0;
    end
  end

  assign REQ_READY = ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign BUSY      = busy_q;
  assign PPI_RESET = ppi_reset_q;
  assign A         = a_q;
  assign CS        = cs_q;
  assign READ      = rd_q;
  assign WRITE     = wr_q;
  assign DATA      = drv_q ? lat_wdata_q : 8'hzz;

endmodule

// File: tb/tb_ppi_bus_master.sv
// ----------------------------------------------------------------------------
// tb_ppi_bus_master
// Directed bench for ppi_bus_master with a behavioural PPI on the bus
// (PA input fixed at 8'h5A, PB/PC/control registers loop back written data).
// Stimulus pushes expected bus shapes, writes and read responses into queues;
// a negedge monitor pops and compares as the DUT produces them.
// ----------------------------------------------------------------------------
module tb_ppi_bus_master;
  import ppi_bus_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_WRITE = 1'b0;
  logic [1:0] REQ_ADDR = 2'b00;
  logic [7:0] REQ_WDATA = 8'h00;
  wire        REQ_READY, RSP_VALID, BUSY, PPI_RESET, CS, READ, WRITE;
  wire  [7:0] RSP_DATA;
  wire  [1:0] A;
  wire  [7:0] DATA;

  ppi_bus_master dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .BUSY(BUSY), .PPI_RESET(PPI_RESET),
    .A(A), .CS(CS), .READ(READ), .WRITE(WRITE), .DATA(DATA)
  );

  always #5 CLK = ~CLK;

  // Behavioural PPI
  logic [7:0] port_a = 8'h5A;
  logic [7:0] pb_q = 8'h00, pc_q = 8'h00, ctrl_q = 8'h00;
  logic [7:0] rd_val;
  always_comb begin
    case (A)
      2'b00:   rd_val = port_a;
      2'b01:   rd_val = pb_q;
      2'b10:   rd_val = pc_q;
      default: rd_val = ctrl_q;
    endcase
  end
  assign DATA = (!CS && !READ) ? rd_val : 8'hzz;

  typedef struct {
    bit wr;
    int cs_len;
    int stb_len;
    int gap;
    bit rsp;
  } shape_t;

  shape_t     shq[$];
  logic [7:0] rq[$];
  logic [9:0] wq[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus monitor / scoreboard
  int   cs_cnt = 0, rd_cnt = 0, wr_cnt = 0, hi_cnt = 0, viol = 0;
  logic prev_cs = 1'b1, prev_wr = 1'b1;
  bit   data_ok = 1'b1;

  always @(negedge CLK) begin
    shape_t     s;
    logic [7:0] e;
    logic [9:0] w;
    if (prev_cs === 1'b1 && CS === 1'b0) begin
      if (shq.size() == 0) check("cs_unexpected", 32'd1, 32'd0);
      else if (shq[0].gap != 0) check("cs_gap", hi_cnt, shq[0].gap);
      cs_cnt = 0; rd_cnt = 0; wr_cnt = 0; data_ok = 1'b1;
    end
    if (prev_cs === 1'b0 && CS === 1'b1) begin
      if (shq.size() == 0) check("cs_rise_unexpected", 32'd1, 32'd0);
      else begin
        s = shq.pop_front();
        check("cs_low_len", cs_cnt, s.cs_len);
        check("strobe_len", s.wr ? wr_cnt : rd_cnt, s.stb_len);
        check("other_strobe", s.wr ? rd_cnt : wr_cnt, 32'd0);
        check("rsp_valid_when_cs_rises", {31'd0, RSP_VALID}, {31'd0, s.rsp});
      end
      hi_cnt = 0;
    end
    if (CS === 1'b0) begin
      cs_cnt++;
      if (shq.size() > 0 && shq[0].wr && wq.size() > 0 && DATA !== wq[0][7:0]) data_ok = 1'b0;
    end
    else hi_cnt++;
    if (READ === 1'b0) rd_cnt++;
    if (WRITE === 1'b0) wr_cnt++;
    if ((READ === 1'b0 && WRITE === 1'b0) || ((READ === 1'b0 || WRITE === 1'b0) && CS !== 1'b0))
      viol++;
    if (prev_wr === 1'b0 && WRITE === 1'b1 && CS === 1'b0) begin
      if (wq.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else begin
        w = wq.pop_front();
        check("wr_addr", A, w[9:8]);
        check("wr_data", DATA, w[7:0]);
        check("wr_data_stable", data_ok, 32'd1);
        case (A)
          2'b01:   pb_q = DATA;
          2'b10:   pc_q = DATA;
          2'b11:   ctrl_q = DATA;
          default: ;
        endcase
      end
    end
    if (RSP_VALID === 1'b1) begin
      if (rq.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else begin
        e = rq.pop_front();
        check("rsp_data", RSP_DATA, e);
      end
    end
    prev_cs = CS;
    prev_wr = WRITE;
  end

  // Issue one request from a negedge; waits (bounded) for REQ_READY.
  task automatic do_req(input bit w, input logic [1:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input int gap, input bit abort);
    int n;
    shape_t s;
    n = 0;
    while (REQ_READY !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (REQ_READY !== 1'b1) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    s.wr = w; s.cs_len = abort ? 3 : 4; s.stb_len = 2; s.gap = gap; s.rsp = !w && !abort;
    shq.push_back(s);
    if (w) wq.push_back({a, d});
    else if (!abort) rq.push_back(exp_rd);
    REQ_VALID = 1'b1; REQ_WRITE = w; REQ_ADDR = a; REQ_WDATA = d;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
  endtask

  initial begin
    shape_t s;
    int n;
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_cs", CS, 32'd1);
    check("rst_read", READ, 32'd1);
    check("rst_write", WRITE, 32'd1);
    check("rst_ready", REQ_READY, 32'd0);
    check("rst_busy", BUSY, 32'd0);
    check("rst_ppi_reset", PPI_RESET, 32'd1);
    check("rst_rsp_valid", RSP_VALID, 32'd0);
    check("rst_rsp_data", RSP_DATA, 32'd0);
    check("rst_addr", A, 32'd0);
`ifdef PPI_INIT_SEQ_EN
    s.wr = 1'b1; s.cs_len = 4; s.stb_len = 2; s.gap = 0; s.rsp = 1'b0;
    shq.push_back(s);
    wq.push_back({PPI_CTRL, PPI_CTRL_WORD_DEFAULT});
    RESET_N = 1'b1;
    @(negedge CLK);
    check("init_ready_low", REQ_READY, 32'd0);
    check("init_busy", BUSY, 32'd1);
`else
    RESET_N = 1'b1;
    @(negedge CLK);
    check("ready_after_release", REQ_READY, 32'd1);
    check("ppi_reset_released", PPI_RESET, 32'd0);
    check("busy_after_release", BUSY, 32'd0);
`endif

    // control write, then read PA
    do_req(1'b1, PPI_CTRL, 8'h9B, 8'h00, 0, 1'b0);
    do_req(1'b0, PPI_PA, 8'h00, 8'h5A, 1, 1'b0);
    // back-to-back write/read PB
    do_req(1'b1, PPI_PB, 8'd15, 8'h00, 1, 1'b0);
    do_req(1'b0, PPI_PB, 8'h00, 8'd15, 1, 1'b0);
    // REQ_VALID toggled while busy must not start extra cycles
    do_req(1'b1, PPI_PC, 8'h33, 8'h00, 1, 1'b0);
    REQ_WRITE = 1'b1; REQ_ADDR = PPI_PA; REQ_WDATA = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      REQ_VALID = (i % 2 == 0);
      @(negedge CLK);
    end
    REQ_VALID = 1'b0;
    do_req(1'b0, PPI_PC, 8'h00, 8'h33, 1, 1'b0);
    // reset during the second STROBE cycle of a read
    do_req(1'b0, PPI_PB, 8'h00, 8'h00, 1, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    check("abort_cs", CS, 32'd1);
    check("abort_read", READ, 32'd1);
    check("abort_write", WRITE, 32'd1);
    check("abort_ppi_reset", PPI_RESET, 32'd1);
    check("abort_rsp_valid", RSP_VALID, 32'd0);
    check("abort_busy", BUSY, 32'd0);
    check("abort_rsp_data", RSP_DATA, 32'd0);
`ifdef PPI_INIT_SEQ_EN
    s.wr = 1'b1; s.cs_len = 4; s.stb_len = 2; s.gap = 0; s.rsp = 1'b0;
    shq.push_back(s);
    wq.push_back({PPI_CTRL, PPI_CTRL_WORD_DEFAULT});
`endif
    RESET_N = 1'b1;
    @(negedge CLK);
    // post-reset read, then a write that must leave RSP_DATA alone
    do_req(1'b0, PPI_PA, 8'h00, 8'h5A, 0, 1'b0);
    do_req(1'b1, PPI_PB, 8'h77, 8'h00, 1, 1'b0);
    do_req(1'b0, PPI_PB, 8'h00, 8'h77, 1, 1'b0);
    do_req(1'b1, PPI_PC, 8'hA5, 8'h00, 1, 1'b0);

    n = 0;
    while ((shq.size() != 0 || rq.size() != 0 || wq.size() != 0) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    repeat (2) @(negedge CLK);
    check("shape_queue_drained", shq.size(), 32'd0);
    check("rsp_queue_drained", rq.size(), 32'd0);
    check("wr_queue_drained", wq.size(), 32'd0);
    check("rsp_data_held", RSP_DATA, 32'h77);
    check("bus_protocol_violations", viol, 32'd0);
    check("final_ready", REQ_READY, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
